// File: rtl/instr_register_pkg.sv
// Shared types and golden arithmetic for the instruction register pipeline.
package instr_register_pkg;

  localparam int OP_WIDTH_DEF  = 32;
  localparam int RES_WIDTH_DEF = 2 * OP_WIDTH_DEF;
  localparam int OPC_W         = 3;

  typedef enum logic [OPC_W-1:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [OP_WIDTH_DEF-1:0]  operand_t;
  typedef logic signed [RES_WIDTH_DEF-1:0] result_t;

  // Field order matches the packed instruction_word port, MSB first.
  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    result_t  rezultat;
  } instr_word_t;

  // Reference arithmetic at the default operand width.
  function automatic result_t alu_compute(opcode_t opc, operand_t a, operand_t b);
    result_t ax;
    result_t bx;
    result_t r;
    ax = a;
    bx = b;
    r  = '0;
    case (opc)
      PASSA: r = ax;
      PASSB: r = bx;
      ADD:   r = ax + bx;
      SUB:   r = ax - bx;
      MULT:  r = ax * bx;
      DIV:   if (b != 0) r = ax / bx;
      MOD:   if (b != 0) r = ax % bx;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic alu_div_zero(opcode_t opc, operand_t b);
    return ((opc == DIV) || (opc == MOD)) && (b == 0);
  endfunction

endpackage

// File: rtl/instr_register_pipe_alu.sv
// Combinational result datapath for the second pipeline stage.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int RES_WIDTH = 2 * OP_WIDTH
) (
  input  logic [OPC_W-1:0]           opc,
  input  logic signed [OP_WIDTH-1:0] op_a,
  input  logic signed [OP_WIDTH-1:0] op_b,
  output logic signed [RES_WIDTH-1:0] rezultat,
  output logic                       div_zero
);

  logic signed [RES_WIDTH-1:0] a_x;
  logic signed [RES_WIDTH-1:0] b_x;
  logic signed [RES_WIDTH-1:0] b_div;
  logic                        b_zero;

  assign a_x    = {{(RES_WIDTH-OP_WIDTH){op_a[OP_WIDTH-1]}}, op_a};
  assign b_x    = {{(RES_WIDTH-OP_WIDTH){op_b[OP_WIDTH-1]}}, op_b};
  assign b_zero = (op_b == '0);
  // Keep the divider input non-zero so its output never goes unknown.
  assign b_div  = b_zero ? {{(RES_WIDTH-1){1'b0}}, 1'b1} : b_x;

  // Opcode decode; ZERO and any unlisted encoding give 0.
  always_comb begin
    rezultat = '0;
    div_zero = 1'b0;
    case (opc)
      PASSA: rezultat = a_x;
      PASSB: rezultat = b_x;
      ADD:   rezultat = a_x + b_x;
      SUB:   rezultat = a_x - b_x;
      MULT:  rezultat = a_x * b_x;
      DIV: begin
        if (b_zero) div_zero = 1'b1;
        else        rezultat = a_x / b_div;
      end
      MOD: begin
        if (b_zero) div_zero = 1'b1;
        else        rezultat = a_x % b_div;
      end
      default: rezultat = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_pipe.sv
// Instruction register file with a two-stage read/ALU pipeline.
module instr_register_pipe
  import instr_register_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int OP_WIDTH  = OP_WIDTH_DEF,
  parameter int AW        = $clog2(DEPTH),
  parameter int RES_WIDTH = 2 * OP_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       reset_n,
  input  logic                                       load_en,
  input  logic [AW-1:0]                              write_pointer,
  input  logic [OPC_W-1:0]                           opcode,
  input  logic [OP_WIDTH-1:0]                        operand_a,
  input  logic [OP_WIDTH-1:0]                        operand_b,
  input  logic                                       rd_en,
  input  logic [AW-1:0]                              read_pointer,
  output logic                                       rd_valid,
  output logic [OPC_W+2*OP_WIDTH+RES_WIDTH-1:0]      instruction_word,
  output logic                                       rd_err,
  output logic                                       div_zero,
  output logic [AW:0]                                entry_count
);

  localparam int EW = OPC_W + 2 * OP_WIDTH;
  localparam int IW = EW + RES_WIDTH;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]      count_q, count_d;

  logic             s1_vld_q, s1_vld_d;
  logic             s1_hit_q, s1_hit_d;
  logic [EW-1:0]    s1_ent_q, s1_ent_d;

  logic             rd_valid_q, rd_valid_d;
  logic [IW-1:0]    word_q, word_d;
  logic             rd_err_q, rd_err_d;
  logic             div_zero_q, div_zero_d;

  logic [EW-1:0]               wr_ent;
  logic signed [RES_WIDTH-1:0] alu_res;
  logic                        alu_dz;

  assign wr_ent = {opcode, operand_a, operand_b};

  // Entry storage, valid bits and occupancy; count only grows on a fresh entry.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    count_d = count_q;
    if (load_en) begin
      mem_d[write_pointer]   = wr_ent;
      valid_d[write_pointer] = 1'b1;
      if (!valid_q[write_pointer]) count_d = count_q + (AW+1)'(1);
    end
  end

  // Stage 1 capture with write-first bypass on an address match.
  always_comb begin
    s1_vld_d = rd_en;
    s1_hit_d = s1_hit_q;
    s1_ent_d = s1_ent_q;
    if (rd_en) begin
      if (load_en && (write_pointer == read_pointer)) begin
        s1_hit_d = 1'b1;
        s1_ent_d = wr_ent;
      end else if (valid_q[read_pointer]) begin
        s1_hit_d = 1'b1;
        s1_ent_d = mem_q[read_pointer];
      end else begin
        s1_hit_d = 1'b0;
        s1_ent_d = '0;
      end
    end
  end

  instr_alu #(
    .OP_WIDTH  (OP_WIDTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_alu (
    .opc      (s1_ent_q[EW-1 -: OPC_W]),
    .op_a     (s1_ent_q[2*OP_WIDTH-1 -: OP_WIDTH]),
    .op_b     (s1_ent_q[OP_WIDTH-1:0]),
    .rezultat (alu_res),
    .div_zero (alu_dz)
  );

  // Stage 2 output register; an invalid entry was captured as all-zero so it yields 0.
  always_comb begin
    rd_valid_d = s1_vld_q;
    word_d     = word_q;
    rd_err_d   = 1'b0;
    div_zero_d = 1'b0;
    if (s1_vld_q) begin
      word_d     = {s1_ent_q, alu_res};
      rd_err_d   = ~s1_hit_q;
      div_zero_d = alu_dz;
    end
  end

  // All state registers; reset drops any read still in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      valid_q    <= '0;
      count_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_hit_q   <= 1'b0;
      s1_ent_q   <= '0;
      rd_valid_q <= 1'b0;
      word_q     <= '0;
      rd_err_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      valid_q    <= valid_d;
      count_q    <= count_d;
      s1_vld_q   <= s1_vld_d;
      s1_hit_q   <= s1_hit_d;
      s1_ent_q   <= s1_ent_d;
      rd_valid_q <= rd_valid_d;
      word_q     <= word_d;
      rd_err_q   <= rd_err_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign rd_valid         = rd_valid_q;
  assign instruction_word = word_q;
  assign rd_err           = rd_err_q;
  assign div_zero         = div_zero_q;
  assign entry_count      = count_q;

endmodule

// File: tb/tb_instr_register_pipe.sv
// Directed bench: vector table of write/read transactions plus pipeline corner sequences.
module tb_instr_register_pipe;
  import instr_register_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          load_en;
  logic [4:0]    write_pointer;
  opcode_t       opcode;
  logic [31:0]   operand_a;
  logic [31:0]   operand_b;
  logic          rd_en;
  logic [4:0]    read_pointer;
  logic          rd_valid;
  logic [130:0]  instruction_word;
  logic          rd_err;
  logic          div_zero;
  logic [5:0]    entry_count;

  int total = 0;
  int bad   = 0;

  instr_register_pipe dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .opcode           (opcode),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .rd_en            (rd_en),
    .read_pointer     (read_pointer),
    .rd_valid         (rd_valid),
    .instruction_word (instruction_word),
    .rd_err           (rd_err),
    .div_zero         (div_zero),
    .entry_count      (entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [4:0]  wa;
    opcode_t     opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  ra;
    logic        e_err;
    logic        e_dz;
    logic [63:0] e_res;
    int          e_cnt;
  } vec_t;

  vec_t        vt [12];
  opcode_t     m_opc [32];
  logic [31:0] m_a   [32];
  logic [31:0] m_b   [32];
  int          exp_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic do_write(input logic [4:0] wa, input opcode_t opc,
                          input logic [31:0] a, input logic [31:0] b);
    load_en = 1'b1; write_pointer = wa; opcode = opc; operand_a = a; operand_b = b;
    tick();
    load_en = 1'b0;
  endtask

  task automatic check_out(input string nm, input logic e_err, input logic e_dz,
                           input logic [63:0] e_res, input opcode_t e_opc,
                           input logic [31:0] e_a, input logic [31:0] e_b);
    instr_word_t w;
    w = instruction_word;
    chk({nm, ".rd_valid"}, 64'(rd_valid), 64'd1);
    chk({nm, ".rd_err"},   64'(rd_err),   64'(e_err));
    chk({nm, ".div_zero"}, 64'(div_zero), 64'(e_dz));
    chk({nm, ".rezultat"}, w.rezultat,    e_res);
    chk({nm, ".fields"},   64'({w.opc, w.op_a, w.op_b}), 64'({e_opc, e_a, e_b}));
  endtask

  // Single read: output must appear exactly two cycles after rd_en and last one cycle.
  task automatic read_check(input string nm, input logic [4:0] ra, input logic e_err,
                            input logic e_dz, input logic [63:0] e_res, input opcode_t e_opc,
                            input logic [31:0] e_a, input logic [31:0] e_b);
    rd_en = 1'b1; read_pointer = ra;
    tick();
    rd_en = 1'b0;
    chk({nm, ".early"}, 64'(rd_valid), 64'd0);
    tick();
    check_out(nm, e_err, e_dz, e_res, e_opc, e_a, e_b);
    tick();
    chk({nm, ".pulse"}, 64'(rd_valid), 64'd0);
  endtask

  // Watch for a pipelined result and compare it against the next queued index.
  task automatic pop_check();
    int idx;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("sweep.extra_valid", 64'd1, 64'd0);
      end else begin
        idx = exp_q.pop_front();
        check_out($sformatf("sweep[%0d]", idx), 1'b0, alu_div_zero(m_opc[idx], m_b[idx]),
                  alu_compute(m_opc[idx], m_a[idx], m_b[idx]), m_opc[idx], m_a[idx], m_b[idx]);
      end
    end
  endtask

  initial begin
    vt[0]  = '{1'b1, 5'd0,  ADD,   32'd5,           32'd3,           5'd0,  1'b0, 1'b0, 64'd8,                  1};
    vt[1]  = '{1'b1, 5'd1,  SUB,   -32'sd15,        32'd4,           5'd1,  1'b0, 1'b0, -64'sd19,               2};
    vt[2]  = '{1'b1, 5'd2,  MULT,  -32'sd7,         32'd6,           5'd2,  1'b0, 1'b0, -64'sd42,               3};
    vt[3]  = '{1'b0, 5'd0,  ZERO,  32'd0,           32'd0,           5'd31, 1'b1, 1'b0, 64'd0,                  3};
    vt[4]  = '{1'b1, 5'd8,  DIV,   32'd9,           32'd0,           5'd8,  1'b0, 1'b1, 64'd0,                  4};
    vt[5]  = '{1'b1, 5'd9,  MOD,   -32'sd7,         32'd2,           5'd9,  1'b0, 1'b0, -64'sd1,                5};
    vt[6]  = '{1'b1, 5'd10, DIV,   -32'sd7,         32'd2,           5'd10, 1'b0, 1'b0, -64'sd3,                6};
    vt[7]  = '{1'b1, 5'd11, MOD,   32'd7,           -32'sd2,         5'd11, 1'b0, 1'b0, 64'd1,                  7};
    vt[8]  = '{1'b1, 5'd12, PASSB, 32'd1,           -32'sd9,         5'd12, 1'b0, 1'b0, -64'sd9,                8};
    vt[9]  = '{1'b1, 5'd0,  ZERO,  32'd4,           32'd4,           5'd0,  1'b0, 1'b0, 64'd0,                  8};
    vt[10] = '{1'b1, 5'd13, MULT,  32'h8000_0000,   32'h8000_0000,   5'd13, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 9};
    vt[11] = '{1'b1, 5'd14, MOD,   32'd0,           32'd0,           5'd14, 1'b0, 1'b1, 64'd0,                  10};

    reset_n = 1'b0; load_en = 1'b0; write_pointer = '0; opcode = ZERO;
    operand_a = '0; operand_b = '0; rd_en = 1'b0; read_pointer = '0;
    tick();
    tick();
    chk("reset.rd_valid", 64'(rd_valid), 64'd0);
    chk("reset.word",     64'(instruction_word[63:0]) | 64'(|instruction_word[130:64]), 64'd0);
    chk("reset.rd_err",   64'(rd_err), 64'd0);
    chk("reset.div_zero", 64'(div_zero), 64'd0);
    chk("reset.count",    64'(entry_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // Table: optional write, then a read of the given address.
    for (int i = 0; i < 12; i++) begin
      if (vt[i].wr) do_write(vt[i].wa, vt[i].opc, vt[i].a, vt[i].b);
      read_check($sformatf("vec%0d", i), vt[i].ra, vt[i].e_err, vt[i].e_dz, vt[i].e_res,
                 vt[i].e_err ? ZERO : vt[i].opc, vt[i].e_err ? 32'd0 : vt[i].a,
                 vt[i].e_err ? 32'd0 : vt[i].b);
      chk($sformatf("vec%0d.count", i), 64'(entry_count), 64'(vt[i].e_cnt));
    end

    // Back-to-back reads produce consecutive pulses in request order.
    do_reset();
    do_write(5'd0, ADD,  32'd5,    32'd3);
    do_write(5'd1, SUB,  -32'sd15, 32'd4);
    do_write(5'd2, MULT, -32'sd7,  32'd6);
    rd_en = 1'b1; read_pointer = 5'd0;
    tick();
    chk("b2b.lat", 64'(rd_valid), 64'd0);
    read_pointer = 5'd1;
    tick();
    check_out("b2b0", 1'b0, 1'b0, 64'd8, ADD, 32'd5, 32'd3);
    read_pointer = 5'd2;
    tick();
    check_out("b2b1", 1'b0, 1'b0, -64'sd19, SUB, -32'sd15, 32'd4);
    rd_en = 1'b0;
    tick();
    check_out("b2b2", 1'b0, 1'b0, -64'sd42, MULT, -32'sd7, 32'd6);
    tick();
    chk("b2b.end", 64'(rd_valid), 64'd0);
    chk("b2b.count", 64'(entry_count), 64'd3);

    // Same-cycle write and read of an unwritten address: write data is bypassed.
    load_en = 1'b1; write_pointer = 5'd4; opcode = PASSA; operand_a = 32'd12; operand_b = 32'd0;
    rd_en = 1'b1; read_pointer = 5'd4;
    tick();
    load_en = 1'b0; rd_en = 1'b0;
    tick();
    check_out("bypass", 1'b0, 1'b0, 64'd12, PASSA, 32'd12, 32'd0);
    chk("bypass.count", 64'(entry_count), 64'd4);

    // Fill every entry, overwrite one, then read all back in reverse, pipelined.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      m_opc[i] = opcode_t'(i % 8);
      m_a[i]   = 32'(i * 7 - 100);
      m_b[i]   = (i % 4 == 2) ? 32'd0 : 32'(i - 13);
      do_write(5'(i), m_opc[i], m_a[i], m_b[i]);
    end
    chk("full.count", 64'(entry_count), 64'd32);
    m_opc[7] = DIV; m_a[7] = -32'sd50; m_b[7] = 32'd7;
    do_write(5'd7, m_opc[7], m_a[7], m_b[7]);
    chk("rewrite.count", 64'(entry_count), 64'd32);
    for (int k = 31; k >= 0; k--) begin
      rd_en = 1'b1; read_pointer = 5'(k);
      exp_q.push_back(k);
      tick();
      pop_check();
    end
    rd_en = 1'b0;
    repeat (3) begin
      tick();
      pop_check();
    end
    chk("sweep.drained", 64'(exp_q.size()), 64'd0);

    // Reset arriving one cycle after rd_en discards the read and all entries.
    rd_en = 1'b1; read_pointer = 5'd3;
    tick();
    rd_en = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst.rd_valid", 64'(rd_valid), 64'd0);
    chk("midrst.count",    64'(entry_count), 64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("midrst.no_pulse", 64'(rd_valid), 64'd0);
    tick();
    chk("midrst.still_idle", 64'(rd_valid), 64'd0);
    read_check("midrst.rd3", 5'd3, 1'b1, 1'b0, 64'd0, ZERO, 32'd0, 32'd0);
    read_check("midrst.rd7", 5'd7, 1'b1, 1'b0, 64'd0, ZERO, 32'd0, 32'd0);
    chk("midrst.count_end", 64'(entry_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
